// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared decode types and constants for the RV32I decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        result_src_e result_src;
        logic        jump;
        logic        branch;
        logic [2:0]  br_cond;
        alu_op_e     alu_ctrl;
        logic        alu_src;
        imm_src_e    imm_src;
        logic        jalr_sel;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/ctrl_decoder.sv
// ============================================================================
// Module      : ctrl_decoder
// Description : Combinational RV32I subset decode to the control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t ctrl,
    output logic         use_rs1,
    output logic         use_rs2,
    output logic         illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        ctrl    = BUBBLE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        illegal = 1'b1;
        case (opcode)
            OPC_OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_I;
                use_rs1        = 1'b1;
                if (funct3 == 3'b000) begin
                    illegal       = 1'b0;
                    ctrl.alu_ctrl = ALU_ADD;
                end else if (funct3 == 3'b001 && funct7 == 7'b0000000) begin
                    illegal       = 1'b0;
                    ctrl.alu_ctrl = ALU_SLL;
                end
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                illegal        = 1'b0;
                case ({funct7, funct3})
                    10'b0000000_000: ctrl.alu_ctrl = ALU_ADD;
                    10'b0100000_000: ctrl.alu_ctrl = ALU_SUB;
                    10'b0000000_111: ctrl.alu_ctrl = ALU_AND;
                    10'b0000000_110: ctrl.alu_ctrl = ALU_OR;
                    10'b0000000_010: ctrl.alu_ctrl = ALU_SLT;
                    default:         illegal       = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_I;
                use_rs1         = 1'b1;
                illegal         = (funct3 != 3'b010);
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
                use_rs1        = 1'b1;
                use_rs2        = 1'b1;
                illegal        = (funct3 != 3'b010);
            end
            OPC_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.br_cond  = funct3;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.imm_src  = IMM_B;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                illegal       = !(funct3 == 3'b000 || funct3 == 3'b001 ||
                                  funct3 == 3'b100 || funct3 == 3'b101);
            end
            OPC_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.imm_src    = IMM_J;
                illegal         = 1'b0;
            end
            OPC_JALR: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.jalr_sel   = 1'b1;
                use_rs1         = 1'b1;
                illegal         = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_IMM;
                ctrl.imm_src    = IMM_U;
                illegal         = 1'b0;
            end
            default: ;
        endcase
        // Illegal encodings must not leak register uses into hazard detection.
        if (illegal) begin
            ctrl    = BUBBLE;
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ctrl_decode_stage.sv
// ============================================================================
// Module      : ctrl_decode_stage
// Description : Registered ID/EX decode stage with stall, flush and load-use
//               bubble insertion. CTRL_ILLEGAL_TRAP_EN adds illegal_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int IMM_SRC_W  = 3,
    parameter int REG_ADDR_W = 5,
    parameter int INSTR_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INSTR_W-1:0]    instr_i,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  hazard_o,
    output logic                  valid_o,
    output logic                  RegWrite_o,
    output logic                  MemWrite_o,
    output logic [1:0]            ResultSrc_o,
    output logic                  Jump_o,
    output logic                  Branch_o,
    output logic [2:0]            BrCond_o,
    output logic [ALU_CTRL_W-1:0] ALUControl_o,
    output logic                  ALUSrc_o,
    output logic [IMM_SRC_W-1:0]  ImmSrc_o,
    output logic                  jalrmuxSel_o,
    output logic [REG_ADDR_W-1:0] rs1_o,
    output logic [REG_ADDR_W-1:0] rs2_o,
    output logic [REG_ADDR_W-1:0] rd_o
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal_o
`endif
);

    ctrl_bundle_t          dec_ctrl;
    logic                  dec_use_rs1;
    logic                  dec_use_rs2;
    logic                  dec_illegal;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;

    ctrl_bundle_t          ex_ctrl,  nxt_ctrl;
    logic                  ex_valid, nxt_valid;
    logic [REG_ADDR_W-1:0] ex_rs1,   nxt_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2,   nxt_rs2;
    logic [REG_ADDR_W-1:0] ex_rd,    nxt_rd;
    logic                  ex_is_load;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                  ex_illegal, nxt_illegal;
`endif

    ctrl_decoder u_decoder (
        .instr   (instr_i[31:0]),
        .ctrl    (dec_ctrl),
        .use_rs1 (dec_use_rs1),
        .use_rs2 (dec_use_rs2),
        .illegal (dec_illegal)
    );

    assign id_rs1 = instr_i[19:15];
    assign id_rs2 = instr_i[24:20];
    assign id_rd  = instr_i[11:7];

    // A load in EX cannot forward in time; stall any consumer of its rd.
    assign ex_is_load = ex_valid && ex_ctrl.reg_write && (ex_ctrl.result_src == RES_MEM);
    assign hazard_o   = valid_i && ex_is_load && (ex_rd != '0) &&
                        ((dec_use_rs1 && (id_rs1 == ex_rd)) ||
                         (dec_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        nxt_ctrl  = BUBBLE;
        nxt_valid = 1'b0;
        nxt_rs1   = '0;
        nxt_rs2   = '0;
        nxt_rd    = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        nxt_illegal = 1'b0;
`endif
        if (!flush_i && !hazard_o && valid_i) begin
            if (!dec_illegal) begin
                nxt_ctrl  = dec_ctrl;
                nxt_valid = 1'b1;
                nxt_rs1   = id_rs1;
                nxt_rs2   = id_rs2;
                nxt_rd    = id_rd;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            nxt_illegal = dec_illegal;
`endif
        end
    end

    // Flush overrides stall; otherwise stall freezes the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl  <= BUBBLE;
            ex_valid <= 1'b0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ex_illegal <= 1'b0;
`endif
        end else if (flush_i || !stall_i) begin
            ex_ctrl  <= nxt_ctrl;
            ex_valid <= nxt_valid;
            ex_rs1   <= nxt_rs1;
            ex_rs2   <= nxt_rs2;
            ex_rd    <= nxt_rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
            ex_illegal <= nxt_illegal;
`endif
        end
    end

    assign valid_o      = ex_valid;
    assign RegWrite_o   = ex_ctrl.reg_write;
    assign MemWrite_o   = ex_ctrl.mem_write;
    assign ResultSrc_o  = ex_ctrl.result_src;
    assign Jump_o       = ex_ctrl.jump;
    assign Branch_o     = ex_ctrl.branch;
    assign BrCond_o     = ex_ctrl.br_cond;
    assign ALUControl_o = ALU_CTRL_W'(ex_ctrl.alu_ctrl);
    assign ALUSrc_o     = ex_ctrl.alu_src;
    assign ImmSrc_o     = IMM_SRC_W'(ex_ctrl.imm_src);
    assign jalrmuxSel_o = ex_ctrl.jalr_sel;
    assign rs1_o        = ex_rs1;
    assign rs2_o        = ex_rs2;
    assign rd_o         = ex_rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_o    = ex_illegal;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ctrl_decode_stage.sv
// ============================================================================
// Module      : tb_ctrl_decode_stage
// Description : Directed table-driven bench for ctrl_decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic        valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        hazard_o, valid_o, RegWrite_o, MemWrite_o, Jump_o, Branch_o;
    logic        ALUSrc_o, jalrmuxSel_o;
    logic [1:0]  ResultSrc_o;
    logic [2:0]  BrCond_o, ALUControl_o, ImmSrc_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_decode_stage dut (
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal_o    (illegal_o),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_i      (instr_i),
        .valid_i      (valid_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .hazard_o     (hazard_o),
        .valid_o      (valid_o),
        .RegWrite_o   (RegWrite_o),
        .MemWrite_o   (MemWrite_o),
        .ResultSrc_o  (ResultSrc_o),
        .Jump_o       (Jump_o),
        .Branch_o     (Branch_o),
        .BrCond_o     (BrCond_o),
        .ALUControl_o (ALUControl_o),
        .ALUSrc_o     (ALUSrc_o),
        .ImmSrc_o     (ImmSrc_o),
        .jalrmuxSel_o (jalrmuxSel_o),
        .rs1_o        (rs1_o),
        .rs2_o        (rs2_o),
        .rd_o         (rd_o)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        hz;
        logic [17:0] c;
        logic        ill;
    } vec_t;

    vec_t tbl[$];

    // Control word: {valid,rw,mw,rsrc[2],j,b,brcond[3],alu[3],alusrc,imm[3],jalr}
    function automatic logic [17:0] ctl(logic v, logic rw, logic mw, logic [1:0] rs,
                                        logic j, logic b, logic [2:0] bc, logic [2:0] alu,
                                        logic as, logic [2:0] im, logic jl);
        return {v, rw, mw, rs, j, b, bc, alu, as, im, jl};
    endfunction

    function automatic logic [32:0] full(logic [17:0] c, logic [31:0] ins);
        return c[17] ? {c, ins[19:15], ins[24:20], ins[11:7]} : {c, 15'b0};
    endfunction

    function automatic logic [32:0] outs();
        return {valid_o, RegWrite_o, MemWrite_o, ResultSrc_o, Jump_o, Branch_o, BrCond_o,
                ALUControl_o, ALUSrc_o, ImmSrc_o, jalrmuxSel_o, rs1_o, rs2_o, rd_o};
    endfunction

    function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_t(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] s_t(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
        return {7'b0, rs2, rs1, f3, 5'b01000, 7'b1100011};
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic add(logic [31:0] ins, logic v, logic hz, logic [17:0] c, logic ill);
        vec_t e;
        e.instr = ins; e.valid = v; e.hz = hz; e.c = c; e.ill = ill;
        tbl.push_back(e);
    endtask

    task automatic drive(logic [31:0] ins, logic v, logic s, logic f);
        instr_i = ins; valid_i = v; stall_i = s; flush_i = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] BUB, C_LW, C_SW, C_JAL, C_JALR, C_LUI;
        logic [31:0] ins, lui_t;
        logic [32:0] held;

        BUB    = '0;
        C_LW   = ctl(1, 1, 0, 2'b01, 0, 0, 3'b000, 3'b000, 1, 3'b000, 0);
        C_SW   = ctl(1, 0, 1, 2'b00, 0, 0, 3'b000, 3'b000, 1, 3'b001, 0);
        C_JAL  = ctl(1, 1, 0, 2'b10, 1, 0, 3'b000, 3'b000, 0, 3'b100, 0);
        C_JALR = ctl(1, 1, 0, 2'b10, 1, 0, 3'b000, 3'b000, 1, 3'b000, 1);
        C_LUI  = ctl(1, 1, 0, 2'b11, 0, 0, 3'b000, 3'b000, 0, 3'b011, 0);
        lui_t  = {20'h00028, 5'd7, 7'b0110111};

        add(32'h00500093, 1, 0, ctl(1,1,0,2'b00,0,0,3'b000,3'b000,1,3'b000,0), 0);
        add(i_t(12'd3, 5'd1, 3'b001, 5'd2, 7'b0010011), 1, 0,
            ctl(1,1,0,2'b00,0,0,3'b000,3'b110,1,3'b000,0), 0);
        add(r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 1, 0, ctl(1,1,0,2'b00,0,0,3'b000,3'b000,0,3'b000,0), 0);
        add(r_t(7'h20, 5'd1, 5'd3, 3'b000, 5'd4), 1, 0, ctl(1,1,0,2'b00,0,0,3'b000,3'b001,0,3'b000,0), 0);
        add(r_t(7'h00, 5'd2, 5'd1, 3'b111, 5'd5), 1, 0, ctl(1,1,0,2'b00,0,0,3'b000,3'b010,0,3'b000,0), 0);
        add(r_t(7'h00, 5'd2, 5'd1, 3'b110, 5'd6), 1, 0, ctl(1,1,0,2'b00,0,0,3'b000,3'b011,0,3'b000,0), 0);
        add(r_t(7'h00, 5'd2, 5'd1, 3'b010, 5'd7), 1, 0, ctl(1,1,0,2'b00,0,0,3'b000,3'b101,0,3'b000,0), 0);
        add(s_t(12'd8, 5'd5, 5'd2), 1, 0, C_SW, 0);
        add(b_t(5'd2, 5'd1, 3'b000), 1, 0, ctl(1,0,0,2'b00,0,1,3'b000,3'b001,0,3'b010,0), 0);
        add(b_t(5'd2, 5'd1, 3'b001), 1, 0, ctl(1,0,0,2'b00,0,1,3'b001,3'b001,0,3'b010,0), 0);
        add(b_t(5'd2, 5'd1, 3'b100), 1, 0, ctl(1,0,0,2'b00,0,1,3'b100,3'b001,0,3'b010,0), 0);
        add(b_t(5'd2, 5'd1, 3'b101), 1, 0, ctl(1,0,0,2'b00,0,1,3'b101,3'b001,0,3'b010,0), 0);
        add({20'h00100, 5'd1, 7'b1101111}, 1, 0, C_JAL, 0);
        add(i_t(12'd0, 5'd2, 3'b000, 5'd1, 7'b1100111), 1, 0, C_JALR, 0);
        add({20'h12345, 5'd7, 7'b0110111}, 1, 0, C_LUI, 0);
        add(i_t(12'd4, 5'd2, 3'b010, 5'd5, 7'b0000011), 1, 0, C_LW, 0);
        add(r_t(7'h00, 5'd1, 5'd5, 3'b000, 5'd6), 1, 1, BUB, 0);
        add(r_t(7'h00, 5'd1, 5'd5, 3'b000, 5'd6), 1, 0, ctl(1,1,0,2'b00,0,0,3'b000,3'b000,0,3'b000,0), 0);
        add(32'hFFFFFFFF, 1, 0, BUB, 1);
        add(32'h00500093, 0, 0, BUB, 0);
        add(i_t(12'd0, 5'd2, 3'b010, 5'd0, 7'b0000011), 1, 0, C_LW, 0);
        add(r_t(7'h00, 5'd1, 5'd0, 3'b000, 5'd6), 1, 0, ctl(1,1,0,2'b00,0,0,3'b000,3'b000,0,3'b000,0), 0);
        add(s_t(12'd5, 5'd3, 5'd2), 1, 0, C_SW, 0);
        add(r_t(7'h00, 5'd1, 5'd5, 3'b000, 5'd6), 1, 0, ctl(1,1,0,2'b00,0,0,3'b000,3'b000,0,3'b000,0), 0);
        add(r_t(7'h00, 5'd2, 5'd1, 3'b001, 5'd6), 1, 0, BUB, 1);
        add(i_t(12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011), 1, 0, C_LW, 0);
        add(s_t(12'd0, 5'd5, 5'd3), 1, 1, BUB, 0);
        add(i_t(12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011), 1, 0, C_LW, 0);
        add(lui_t, 1, 0, C_LUI, 0);

        // Reset state
        #2;
        chk("reset_outs", 64'(outs()), 64'(0));
        chk("reset_hazard", 64'(hazard_o), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].instr, tbl[i].valid, 1'b0, 1'b0);
            #1;
            chk($sformatf("vec%0d_hazard", i), 64'(hazard_o), 64'(tbl[i].hz));
            tick();
            chk($sformatf("vec%0d_outs", i), 64'(outs()), 64'(full(tbl[i].c, tbl[i].instr)));
`ifdef CTRL_ILLEGAL_TRAP_EN
            chk($sformatf("vec%0d_illegal", i), 64'(illegal_o), 64'(tbl[i].ill));
`endif
        end

        // flush and stall together while sw is held
        ins = s_t(12'd8, 5'd5, 5'd2);
        drive(ins, 1, 0, 0);
        tick();
        chk("sw_loaded", 64'(outs()), 64'(full(C_SW, ins)));
        drive(32'h00500093, 1, 1, 1);
        tick();
        chk("flush_over_stall", 64'(outs()), 64'(0));

        // hazard is visible during a stall; register holds the load
        ins = i_t(12'd0, 5'd2, 3'b010, 5'd5, 7'b0000011);
        drive(ins, 1, 0, 0);
        tick();
        held = full(C_LW, ins);
        drive(r_t(7'h00, 5'd1, 5'd5, 3'b000, 5'd6), 1, 1, 0);
        #1;
        chk("hazard_in_stall", 64'(hazard_o), 64'(1));
        tick();
        chk("stall_holds_lw", 64'(outs()), 64'(held));

        // flush with a simultaneous hazard
        drive(r_t(7'h00, 5'd1, 5'd5, 3'b000, 5'd6), 1, 0, 1);
        #1;
        chk("hazard_with_flush", 64'(hazard_o), 64'(1));
        tick();
        chk("flush_bubble", 64'(outs()), 64'(0));

        // bne held across a 3-cycle stall, then async reset mid-stall
        ins = b_t(5'd2, 5'd1, 3'b001);
        drive(ins, 1, 0, 0);
        tick();
        held = full(ctl(1,0,0,2'b00,0,1,3'b001,3'b001,0,3'b010,0), ins);
        chk("bne_loaded", 64'(outs()), 64'(held));
        for (int k = 0; k < 3; k++) begin
            drive(32'h00500093, 1, 1, 0);
            tick();
            chk($sformatf("stall_hold%0d", k), 64'(outs()), 64'(held));
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 64'(outs()), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h0, 0, 0, 0);
        tick();
        chk("post_reset_idle", 64'(outs()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
